hex_scroll_ctrl: RTL and testbench

Sequences the six 7-segment displays (HEX0..HEX5) as a scrolling message window over a 16-entry digit buffer. A simple write port fills the buffer. Four raw push-buttons control the scroll: pause, direction, home and speed. The block sits between the processor-side parallel outputs / fabric logic and the board HEX pins, and owns display timing so software only writes message content.

---
 rtl/hex_scroll_ctrl.sv | 177 +++++++++++++++++
 tb/tb_hex_scroll_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_scroll_ctrl.sv
// Purpose: scrolls a six-digit window over a 16-entry digit buffer, with debounced key control.
// Latency: buffer/pos changes reach hex0..hex5 one clock later; key presses act after sync plus debounce.
// Backpressure: none; the write port accepts one entry every cycle and keys are sampled continuously.
module hex_scroll_ctrl #(
  parameter int TICK_DIV        = 12500000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic [4:0] msg_len,
  input  logic [3:0] key_n,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic       running,
  output logic       dir,
  output logic       fast,
  output logic [3:0] pos
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [TW-1:0] TERM_SLOW = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TERM_FAST = TW'(TICK_DIV / 2 - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  // Key path: raw active-low levels, two-flop sync, accepted (debounced) level
  logic [3:0]    key_s1;
  logic [3:0]    key_s2;
  logic [3:0]    key_acc;
  logic [DW-1:0] deb_cnt [4];
  logic [3:0]    press;

  // Scroll state
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] term;
  logic          step;
  logic [4:0]    len_eff;
  logic [4:0]    pos_ext;
  logic [3:0]    step_pos;

  // Message buffer and registered segment outputs
  logic [4:0] buf_q [16];
  logic [6:0] hex_q [6];

  // Active-low segment pattern {g,f,e,d,c,b,a}; bit4 of the entry forces blank
  function automatic logic [6:0] seg7(input logic [4:0] e);
    logic [6:0] s;
    if (e[4]) begin
      s = 7'h7F;
    end else begin
      case (e[3:0])
        4'h0:    s = 7'h40;
        4'h1:    s = 7'h79;
        4'h2:    s = 7'h24;
        4'h3:    s = 7'h30;
        4'h4:    s = 7'h19;
        4'h5:    s = 7'h12;
        4'h6:    s = 7'h02;
        4'h7:    s = 7'h78;
        4'h8:    s = 7'h00;
        4'h9:    s = 7'h10;
        4'hA:    s = 7'h08;
        4'hB:    s = 7'h03;
        4'hC:    s = 7'h46;
        4'hD:    s = 7'h21;
        4'hE:    s = 7'h06;
        default: s = 7'h0E;
      endcase
    end
    return s;
  endfunction

  // Window index wrapped into the active message; len is never zero here
  function automatic logic [3:0] wrap_idx(input logic [4:0] sum, input logic [4:0] len);
    return 4'(sum % len);
  endfunction

  // Press pulse on the cycle the accepted level flips from released to pressed
  always_comb begin
    press = '0;
    for (int i = 0; i < 4; i++) begin
      press[i] = (key_s2[i] != key_acc[i]) && (deb_cnt[i] == DEB_LAST) && !key_s2[i];
    end
  end

  // Synchronise keys and accept a new level only after a full run of stable cycles
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      key_s1  <= '1;
      key_s2  <= '1;
      key_acc <= '1;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      for (int i = 0; i < 4; i++) begin
        if (key_s2[i] == key_acc[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          key_acc[i] <= key_s2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Effective length, step period and the position a step would move to
  always_comb begin
    if (msg_len == 5'd0)       len_eff = 5'd1;
    else if (msg_len > 5'd16)  len_eff = 5'd16;
    else                       len_eff = msg_len;
    pos_ext = {1'b0, pos};
    term    = fast ? TERM_FAST : TERM_SLOW;
    step    = running && (tick_cnt == term);
    if (!dir) step_pos = (pos_ext + 5'd1 == len_eff) ? 4'd0 : pos + 4'd1;
    else      step_pos = (pos == 4'd0) ? 4'(len_eff - 5'd1) : pos - 4'd1;
  end

  // Mode toggles, tick counter and window position; home beats length fix-up beats step
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      running  <= 1'b1;
      dir      <= 1'b0;
      fast     <= 1'b0;
      pos      <= 4'd0;
      tick_cnt <= '0;
    end else begin
      if (press[0]) running <= ~running;
      if (press[1]) dir     <= ~dir;
      if (press[3]) fast    <= ~fast;

      if (press[2] || press[3])  tick_cnt <= '0;
      else if (running)          tick_cnt <= (tick_cnt == term) ? '0 : tick_cnt + 1'b1;

      if (press[2])                pos <= 4'd0;
      else if (pos_ext >= len_eff) pos <= 4'd0;
      else if (step)               pos <= step_pos;
    end
  end

  // Buffer write port; out-of-window entries are kept for later
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 16; i++) buf_q[i] <= 5'h10;
    end else if (wr_en) begin
      buf_q[wr_addr] <= wr_data;
    end
  end

  // Register the segment patterns; hex5 shows buf[pos], hex0 shows buf[pos+5]
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      for (int n = 0; n < 6; n++) hex_q[n] <= 7'h7F;
    end else begin
      for (int n = 0; n < 6; n++) begin
        hex_q[n] <= seg7(buf_q[wrap_idx(pos_ext + 5'(5 - n), len_eff)]);
      end
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Directed bench for hex_scroll_ctrl with short tick and debounce periods.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Each scenario task checks its own expectations inline.
module tb_hex_scroll_ctrl;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [4:0] wr_data;
  logic [4:0] msg_len;
  logic [3:0] key_n;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic       running, dir, fast;
  logic [3:0] pos;
  logic [6:0] hx [6];

  int checks = 0;
  int errors = 0;

  always #5 clk_clk = ~clk_clk;

  assign hx[0] = hex0;
  assign hx[1] = hex1;
  assign hx[2] = hex2;
  assign hx[3] = hex3;
  assign hx[4] = hex4;
  assign hx[5] = hex5;

  hex_scroll_ctrl #(.TICK_DIV(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .key_n(key_n),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .running(running), .dir(dir), .fast(fast), .pos(pos)
  );

  // Hand-written segment table for digits 0..F
  function automatic logic [6:0] exp_seg(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  task automatic write_buf(input logic [3:0] a, input logic [4:0] d);
    wr_addr = a;
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk_clk);
    wr_en   = 1'b0;
  endtask

  // Cycles until pos next changes, or -1 if it does not within the budget
  task automatic wait_pos_change(output int n);
    logic [3:0] p0;
    p0 = pos;
    n  = 0;
    while (pos == p0 && n < 100) begin
      @(negedge clk_clk);
      n++;
    end
    if (pos == p0) n = -1;
  endtask

  // Stop on the falling edge right after pos has just become target
  task automatic wait_pos(input logic [3:0] target, output bit ok);
    int n;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      wait_pos_change(n);
      if (n < 0) break;
      if (pos == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic press_key(input int k);
    key_n[k] = 1'b0;
    tick(10);
    key_n[k] = 1'b1;
    tick(10);
  endtask

  task automatic test_reset;
    reset_reset_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    msg_len = 5'd10; key_n = 4'hF;
    tick(2);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (hx[i] !== 7'h7F) begin
        errors++;
        $display("FAIL reset_hex%0d got %h want 7f", i, hx[i]);
      end
    end
    checks++;
    if (pos !== 4'd0) begin errors++; $display("FAIL reset_pos got %0d want 0", pos); end
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL reset_running got %b want 1", running); end
    checks++;
    if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir got %b want 0", dir); end
    checks++;
    if (fast !== 1'b0) begin errors++; $display("FAIL reset_fast got %b want 0", fast); end
    reset_reset_n = 1'b1;
  endtask

  task automatic test_fill_scroll;
    bit ok;
    int n;
    for (int d = 0; d < 10; d++) write_buf(4'(d), 5'(d));
    wait_pos(4'd0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fill_sync pos=%0d never wrapped to 0", pos); end
    for (int i = 0; i < 10; i++) begin
      wait_pos_change(n);
      checks++;
      if (n !== 8 || pos !== 4'((i + 1) % 10)) begin
        errors++;
        $display("FAIL scroll_step%0d got period %0d pos %0d want 8 pos %0d", i, n, pos, (i + 1) % 10);
      end
    end
    tick(1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (hx[5 - i] !== exp_seg(i)) begin
        errors++;
        $display("FAIL fill_hex%0d got %h want %h", 5 - i, hx[5 - i], exp_seg(i));
      end
    end
  endtask

  task automatic test_dir_speed;
    bit ok;
    int n;
    logic [3:0] prev;
    press_key(1);
    checks++;
    if (dir !== 1'b1) begin errors++; $display("FAIL dir_toggle got %b want 1", dir); end
    wait_pos(4'd0, ok);
    wait_pos_change(n);
    checks++;
    if (!ok || pos !== 4'd9 || n !== 8) begin
      errors++;
      $display("FAIL dir_wrap got pos %0d period %0d want pos 9 period 8", pos, n);
    end
    press_key(3);
    checks++;
    if (fast !== 1'b1) begin errors++; $display("FAIL fast_toggle got %b want 1", fast); end
    wait_pos_change(n);
    for (int i = 0; i < 2; i++) begin
      prev = pos;
      wait_pos_change(n);
      checks++;
      if (n !== 4 || pos !== ((prev == 4'd0) ? 4'd9 : prev - 4'd1)) begin
        errors++;
        $display("FAIL fast_step%0d got period %0d pos %0d from %0d want period 4", i, n, pos, prev);
      end
    end
  endtask

  task automatic test_debounce;
    int toggles;
    logic prev_run;
    logic [3:0] p;
    repeat (3) begin
      key_n[0] = 1'b0; tick(2);
      key_n[0] = 1'b1; tick(2);
    end
    tick(6);
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL glitch_ignored running got %b want 1", running); end
    key_n[0] = 1'b0;
    toggles  = 0;
    prev_run = running;
    repeat (20) begin
      tick(1);
      if (running !== prev_run) toggles++;
      prev_run = running;
    end
    checks++;
    if (toggles !== 1 || running !== 1'b0) begin
      errors++;
      $display("FAIL hold_one_toggle got %0d toggles running %b want 1 toggle running 0", toggles, running);
    end
    p = pos;
    tick(50);
    checks++;
    if (pos !== p) begin errors++; $display("FAIL paused_pos got %0d want %0d", pos, p); end
    key_n[0] = 1'b1;
    tick(10);
    press_key(0);
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL resume got running %b want 1", running); end
  endtask

  task automatic test_boundaries;
    bit ok;
    int n;
    wait_pos(4'd7, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reach_pos7 got pos %0d", pos); end
    msg_len = 5'd5;
    tick(1);
    checks++;
    if (pos !== 4'd0) begin errors++; $display("FAIL len_fixup got pos %0d want 0", pos); end
    tick(1);
    checks++;
    if (hex5 !== 7'h40 || hex1 !== 7'h19 || hex0 !== 7'h40) begin
      errors++;
      $display("FAIL len5_repeat got hex5 %h hex1 %h hex0 %h want 40 19 40", hex5, hex1, hex0);
    end
    msg_len = 5'd0;
    tick(2);
    checks++;
    if (pos !== 4'd0) begin errors++; $display("FAIL len0_pos got %0d want 0", pos); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (hx[i] !== 7'h40) begin errors++; $display("FAIL len0_hex%0d got %h want 40", i, hx[i]); end
    end
    for (int d = 10; d < 16; d++) write_buf(4'(d), 5'(d));
    msg_len = 5'd31;
    wait_pos_change(n);
    checks++;
    if (pos !== 4'd15) begin errors++; $display("FAIL len31_wrap got pos %0d want 15", pos); end
    tick(1);
    checks++;
    if (hex5 !== 7'h0E || hex4 !== 7'h40 || hex0 !== 7'h19) begin
      errors++;
      $display("FAIL len31_hex got hex5 %h hex4 %h hex0 %h want 0e 40 19", hex5, hex4, hex0);
    end
  endtask

  task automatic test_simultaneous;
    bit ok;
    int n;
    // Home press timed so its event lands on the same edge as a terminal tick
    wait_pos(4'd10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reach_pos10 got pos %0d", pos); end
    tick(2);
    key_n[2] = 1'b0;
    tick(5);
    checks++;
    if (pos !== 4'd9) begin errors++; $display("FAIL pre_home_pos got %0d want 9", pos); end
    tick(1);
    checks++;
    if (pos !== 4'd0) begin errors++; $display("FAIL home_on_tick got pos %0d want 0", pos); end
    wait_pos_change(n);
    checks++;
    if (n !== 4 || pos !== 4'd15) begin
      errors++;
      $display("FAIL home_tick_clear got period %0d pos %0d want 4 pos 15", n, pos);
    end
    key_n[2] = 1'b1;
    tick(10);
    // Write the entry that is about to become pos on the same edge as the step
    wait_pos(4'd12, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reach_pos12 got pos %0d", pos); end
    tick(3);
    wr_addr = 4'd11;
    wr_data = 5'd7;
    wr_en   = 1'b1;
    tick(1);
    wr_en   = 1'b0;
    checks++;
    if (pos !== 4'd11) begin errors++; $display("FAIL step_with_write pos got %0d want 11", pos); end
    tick(2);
    checks++;
    if (hex5 !== 7'h78 || hex4 !== 7'h46) begin
      errors++;
      $display("FAIL write_visible got hex5 %h hex4 %h want 78 46", hex5, hex4);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_scroll();
    test_dir_speed();
    test_debounce();
    test_boundaries();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
